// File: rtl/clk_pkg.sv
// clk_pkg: shared mode states and default timing constants for the clock time-set controller
package clk_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10,
    SET_SEC  = 2'b11
  } mode_t;
  localparam int DEB_CYC    = 20;
  localparam int REP_DLY    = 500;
  localparam int REP_PER    = 200;
  localparam int BLINK_HALF = 250;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stability debouncer and registered one-cycle press pulse
module btn_debounce #(
  parameter int DEB_CYC = 20
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press
);
  localparam int W = $clog2(DEB_CYC + 1);
  logic [1:0] sync;
  logic [W-1:0] cnt;
  logic level_q;
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      sync    <= '0;
      cnt     <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync    <= {sync[0], btn};
      level_q <= level;
      press   <= level & ~level_q;
      // any cycle agreeing with the accepted level restarts the stability count
      if (sync[1] == level) cnt <= '0;
      else if (cnt >= W'(DEB_CYC - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/clk_set_ctrl.sv
// clk_set_ctrl: RUN/SET mode FSM with debounced buttons, inc auto-repeat and edit-digit blink
module clk_set_ctrl
  import clk_pkg::*;
#(
  parameter int DEB_CYC    = clk_pkg::DEB_CYC,
  parameter int REP_DLY    = clk_pkg::REP_DLY,
  parameter int REP_PER    = clk_pkg::REP_PER,
  parameter int BLINK_HALF = clk_pkg::BLINK_HALF
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_clr,
  output logic       en,
  output logic       rst_counters,
  output logic       enc_sec,
  output logic       enc_min,
  output logic       enc_hour,
  output logic       blink,
  output logic [1:0] mode_state
);
  localparam int REP_MAX = REP_DLY > REP_PER ? REP_DLY : REP_PER;
  localparam int RW = $clog2(REP_MAX + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);
  mode_t state;
  logic mode_p, inc_p, clr_p, inc_lvl, unused_mode_lvl, unused_clr_lvl;
  logic rep_act, rep_first, rep_hit, fire;
  logic [RW-1:0] rep_cnt;
  logic [BW-1:0] blink_cnt;
  btn_debounce #(.DEB_CYC(DEB_CYC)) u_mode (.CLK(CLK), .rst_n(rst_n), .btn(btn_mode), .level(unused_mode_lvl), .press(mode_p));
  btn_debounce #(.DEB_CYC(DEB_CYC)) u_inc  (.CLK(CLK), .rst_n(rst_n), .btn(btn_inc),  .level(inc_lvl),         .press(inc_p));
  btn_debounce #(.DEB_CYC(DEB_CYC)) u_clr  (.CLK(CLK), .rst_n(rst_n), .btn(btn_clr),  .level(unused_clr_lvl),  .press(clr_p));
  assign en = state == RUN;
  assign mode_state = state;
  // a mode press in the same cycle swallows the increment
  always_comb begin
    rep_hit = rep_act && inc_lvl && rep_cnt >= (rep_first ? RW'(REP_DLY) : RW'(REP_PER));
    fire = state != RUN && !mode_p && (inc_p || rep_hit);
  end
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      state        <= RUN;
      rst_counters <= 1'b0;
      enc_sec      <= 1'b0;
      enc_min      <= 1'b0;
      enc_hour     <= 1'b0;
      blink        <= 1'b0;
      blink_cnt    <= '0;
      rep_cnt      <= '0;
      rep_act      <= 1'b0;
      rep_first    <= 1'b0;
    end else begin
      rst_counters <= clr_p;
      enc_hour     <= fire && state == SET_HOUR;
      enc_min      <= fire && state == SET_MIN;
      enc_sec      <= fire && state == SET_SEC;
      if (mode_p) state <= mode_t'(state + 2'd1);
      // rep_cnt counts cycles since the last strobe; first gap is REP_DLY, later ones REP_PER
      if (mode_p || !inc_lvl) begin
        rep_act <= 1'b0;
        rep_cnt <= '0;
      end else if (fire) begin
        rep_act   <= 1'b1;
        rep_first <= inc_p;
        rep_cnt   <= RW'(1);
      end else if (rep_act && rep_cnt < RW'(REP_MAX)) rep_cnt <= rep_cnt + 1'b1;
      if (mode_p) begin
        blink_cnt <= '0;
        blink     <= state != SET_SEC;
      end else if (state == RUN) begin
        blink_cnt <= '0;
        blink     <= 1'b0;
      end else if (blink_cnt >= BW'(BLINK_HALF - 1)) begin
        blink_cnt <= '0;
        blink     <= !blink;
      end else blink_cnt <= blink_cnt + 1'b1;
    end
endmodule

// File: tb/tb_clk_set_ctrl.sv
// tb_clk_set_ctrl: directed bench for the time-set controller with hand-computed cycle timing
module tb_clk_set_ctrl;
  logic CLK = 1'b0;
  logic rst_n = 1'b0;
  logic btn_mode = 1'b0, btn_inc = 1'b0, btn_clr = 1'b0;
  logic en, rst_counters, enc_sec, enc_min, enc_hour, blink;
  logic [1:0] mode_state;
  int checks = 0;
  int fails = 0;
  clk_set_ctrl dut (
    .CLK(CLK), .rst_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_clr(btn_clr),
    .en(en), .rst_counters(rst_counters), .enc_sec(enc_sec), .enc_min(enc_min),
    .enc_hour(enc_hour), .blink(blink), .mode_state(mode_state)
  );
  always #5 CLK = ~CLK;
  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask
  task automatic press_mode;
    btn_mode = 1'b1;
    tick(30);
    btn_mode = 1'b0;
    tick(30);
  endtask
  task automatic test_reset;
    tick(5);
    checks++;
    if ({en, mode_state, rst_counters, enc_sec, enc_min, enc_hour, blink} !== 8'b1_00_00000) begin
      fails++;
      $display("FAIL reset_outputs got en=%b mode=%b rst=%b enc=%b%b%b blink=%b want en=1 mode=00 others 0",
               en, mode_state, rst_counters, enc_hour, enc_min, enc_sec, blink);
    end
    rst_n = 1'b1;
    tick(3);
    checks++;
    if (mode_state !== 2'b00 || en !== 1'b1) begin
      fails++;
      $display("FAIL reset_release got mode=%b en=%b want 00/1", mode_state, en);
    end
  endtask
  task automatic test_mode_cycle;
    logic [1:0] want;
    for (int i = 0; i < 4; i++) begin
      want = 2'(i + 1);
      btn_mode = 1'b1;
      tick(23);
      checks++;
      if (mode_state !== 2'(i)) begin
        fails++;
        $display("FAIL mode_early_%0d got %b want %b", i, mode_state, 2'(i));
      end
      tick(1);
      checks++;
      if (mode_state !== want || en !== (want == 2'b00) || blink !== (want != 2'b00)) begin
        fails++;
        $display("FAIL mode_step_%0d got mode=%b en=%b blink=%b want mode=%b en=%b blink=%b",
                 i, mode_state, en, blink, want, want == 2'b00, want != 2'b00);
      end
      tick(26);
      btn_mode = 1'b0;
      tick(50);
    end
  endtask
  task automatic test_bounce_blink;
    for (int i = 0; i < 10; i++) begin
      btn_mode = 1'b1;
      tick(3);
      btn_mode = 1'b0;
      tick(3);
    end
    tick(20);
    checks++;
    if (mode_state !== 2'b00) begin
      fails++;
      $display("FAIL bounce_reject got %b want 00", mode_state);
    end
    btn_mode = 1'b1;
    tick(23);
    checks++;
    if (mode_state !== 2'b00) begin
      fails++;
      $display("FAIL bounce_early got %b want 00", mode_state);
    end
    tick(1);
    checks++;
    if (mode_state !== 2'b01 || blink !== 1'b1) begin
      fails++;
      $display("FAIL bounce_accept got mode=%b blink=%b want 01/1", mode_state, blink);
    end
    tick(249);
    checks++;
    if (blink !== 1'b1) begin
      fails++;
      $display("FAIL blink_hold got %b want 1", blink);
    end
    tick(1);
    checks++;
    if (blink !== 1'b0) begin
      fails++;
      $display("FAIL blink_toggle got %b want 0", blink);
    end
    btn_mode = 1'b0;
    tick(30);
  endtask
  task automatic test_inc_repeat;
    int hits[$];
    int want_k[5] = '{24, 524, 724, 924, 1124};
    int other = 0;
    btn_inc = 1'b1;
    for (int k = 1; k <= 1400; k++) begin
      if (k == 1201) btn_inc = 1'b0;
      @(negedge CLK);
      if (enc_min) hits.push_back(k);
      if (enc_sec || enc_hour) other++;
    end
    checks++;
    if (hits.size() != 5) begin
      fails++;
      $display("FAIL repeat_count got %0d pulses want 5", hits.size());
    end
    for (int i = 0; i < 5 && i < hits.size(); i++) begin
      checks++;
      if (hits[i] != want_k[i]) begin
        fails++;
        $display("FAIL repeat_time_%0d got cycle %0d want %0d", i, hits[i], want_k[i]);
      end
    end
    checks++;
    if (other != 0 || mode_state !== 2'b10) begin
      fails++;
      $display("FAIL repeat_other got stray=%0d mode=%b want 0/10", other, mode_state);
    end
  endtask
  task automatic test_simultaneous;
    int sec_hits = 0;
    btn_mode = 1'b1;
    btn_inc = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge CLK);
      if (enc_sec || enc_min || enc_hour) sec_hits++;
    end
    checks++;
    if (mode_state !== 2'b00 || en !== 1'b1 || sec_hits != 0) begin
      fails++;
      $display("FAIL simul_mode_inc got mode=%b en=%b enc_pulses=%0d want 00/1/0", mode_state, en, sec_hits);
    end
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    tick(30);
  endtask
  task automatic test_run_inc_clear;
    int enc_hits = 0;
    int clr_hits = 0;
    btn_inc = 1'b1;
    for (int k = 1; k <= 600; k++) begin
      if (k == 101) btn_inc = 1'b0;
      @(negedge CLK);
      if (enc_sec || enc_min || enc_hour) enc_hits++;
    end
    checks++;
    if (enc_hits != 0) begin
      fails++;
      $display("FAIL run_inc got %0d enc pulses want 0", enc_hits);
    end
    btn_clr = 1'b1;
    tick(23);
    checks++;
    if (rst_counters !== 1'b0) begin
      fails++;
      $display("FAIL clr_early got %b want 0", rst_counters);
    end
    tick(1);
    checks++;
    if (rst_counters !== 1'b1 || mode_state !== 2'b00) begin
      fails++;
      $display("FAIL clr_pulse got rst=%b mode=%b want 1/00", rst_counters, mode_state);
    end
    for (int k = 1; k <= 60; k++) begin
      if (k == 30) btn_clr = 1'b0;
      @(negedge CLK);
      if (rst_counters) clr_hits++;
    end
    checks++;
    if (clr_hits != 0 || mode_state !== 2'b00) begin
      fails++;
      $display("FAIL clr_single got extra=%0d mode=%b want 0/00", clr_hits, mode_state);
    end
  endtask
  task automatic test_inc_clear_set;
    btn_inc = 1'b1;
    btn_clr = 1'b1;
    tick(23);
    checks++;
    if (enc_hour !== 1'b0 || rst_counters !== 1'b0) begin
      fails++;
      $display("FAIL incclr_early got enc_hour=%b rst=%b want 0/0", enc_hour, rst_counters);
    end
    tick(1);
    checks++;
    if (enc_hour !== 1'b1 || rst_counters !== 1'b1 || mode_state !== 2'b01 || enc_min !== 1'b0 || enc_sec !== 1'b0) begin
      fails++;
      $display("FAIL incclr_both got enc=%b%b%b rst=%b mode=%b want 100/1/01",
               enc_hour, enc_min, enc_sec, rst_counters, mode_state);
    end
    tick(1);
    checks++;
    if (enc_hour !== 1'b0 || rst_counters !== 1'b0) begin
      fails++;
      $display("FAIL incclr_width got enc_hour=%b rst=%b want 0/0", enc_hour, rst_counters);
    end
    btn_inc = 1'b0;
    btn_clr = 1'b0;
    tick(30);
  endtask
  task automatic test_async_reset;
    int enc_hits = 0;
    btn_inc = 1'b1;
    tick(10);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mode_state !== 2'b00 || en !== 1'b1 || blink !== 1'b0 || rst_counters !== 1'b0) begin
      fails++;
      $display("FAIL async_reset got mode=%b en=%b blink=%b rst=%b want 00/1/0/0", mode_state, en, blink, rst_counters);
    end
    tick(3);
    rst_n = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge CLK);
      if (enc_sec || enc_min || enc_hour) enc_hits++;
    end
    checks++;
    if (enc_hits != 0 || mode_state !== 2'b00) begin
      fails++;
      $display("FAIL async_after got enc_pulses=%0d mode=%b want 0/00", enc_hits, mode_state);
    end
    btn_inc = 1'b0;
    tick(30);
  endtask
  initial begin
    test_reset;
    test_mode_cycle;
    test_bounce_blink;
    press_mode;
    test_inc_repeat;
    press_mode;
    checks++;
    if (mode_state !== 2'b11) begin
      fails++;
      $display("FAIL enter_set_sec got %b want 11", mode_state);
    end
    test_simultaneous;
    test_run_inc_clear;
    press_mode;
    test_inc_clear_set;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
